// File: rtl/kb_read_sequencer.sv
// kb_read_sequencer: pulls translated ASCII bytes from the keyboard scan FIFO,
// discards untranslatable codes (0x00) and buffers the rest in a small
// first-word-fall-through FIFO with a valid/ready consumer interface.
module kb_read_sequencer #(
  parameter int unsigned DEPTH_LOG2 = 2,
  parameter int unsigned HOLDOFF    = 2
) (
  input  logic                  clk,
  input  logic                  Reset,
  input  logic                  kb_avail,
  input  logic [7:0]            kb_ascii,
  output logic                  kb_rd,
  output logic [7:0]            out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DEPTH_LOG2:0]   fifo_level,
  output logic [7:0]            drop_count,
  output logic                  busy
);

  localparam int unsigned        DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] LVL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [3:0]          HOLD_INIT = 4'(HOLDOFF - 1);

  typedef enum logic [1:0] {S_IDLE, S_LATCH, S_POP, S_HOLD} state_e;

  state_e                state_q, state_d;
  logic [7:0]            cap_q, cap_d;
  logic [3:0]            hold_q, hold_d;
  logic [7:0]            mem_q [DEPTH];
  logic [7:0]            mem_d [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   level_q, level_d;
  logic [7:0]            out_data_q, out_data_d;
  logic                  out_valid_q, out_valid_d;
  logic [7:0]            drop_q, drop_d;
  logic                  kb_rd_q, kb_rd_d;
  logic                  busy_q, busy_d;
  logic                  wr_en, rd_en;

  // State and datapath registers; reset aborts any in-flight sequence.
  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q     <= S_IDLE;
      cap_q       <= '0;
      hold_q      <= '0;
      mem_q       <= '{default: '0};
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      drop_q      <= '0;
      kb_rd_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cap_q       <= cap_d;
      hold_q      <= hold_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      drop_q      <= drop_d;
      kb_rd_q     <= kb_rd_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state: a key is only started when the local FIFO has room for it.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (kb_avail && (level_q < LVL_FULL)) state_d = S_LATCH;
      S_LATCH: state_d = S_POP;
      S_POP:   state_d = S_HOLD;
      S_HOLD:  if (hold_q == '0) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs and datapath: capture, pop strobe, drop counting, local FIFO.
  always_comb begin
    cap_d      = cap_q;
    hold_d     = hold_q;
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    out_data_d = out_data_q;
    drop_d     = drop_q;

    wr_en = (state_q == S_POP) && (cap_q != 8'h00);
    rd_en = out_valid_q && out_ready;

    if (state_q == S_LATCH) cap_d = kb_ascii;

    if (state_q == S_POP) hold_d = HOLD_INIT;
    else if ((state_q == S_HOLD) && (hold_q != '0)) hold_d = hold_q - 4'd1;

    if ((state_q == S_POP) && (cap_q == 8'h00) && (drop_q != '1)) drop_d = drop_q + 8'd1;

    if (wr_en) begin
      mem_d[wr_ptr_q] = cap_q;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;

    unique case ({wr_en, rd_en})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase

    out_valid_d = (level_d != '0);
    // out_data is registered, so the next head is looked up here; when the new
    // head is the slot being written this edge, mem_q is not yet updated and
    // the captured byte is forwarded instead. Empty keeps the last value.
    if (level_d != '0) begin
      if (wr_en && (rd_ptr_d == wr_ptr_q)) out_data_d = cap_q;
      else                                 out_data_d = mem_q[rd_ptr_d];
    end

    kb_rd_d = (state_d == S_POP);
    busy_d  = (state_d != S_IDLE);
  end

  assign kb_rd      = kb_rd_q;
  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign fifo_level = level_q;
  assign drop_count = drop_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_kb_read_sequencer.sv
// Directed bench for kb_read_sequencer with a behavioural keyboard scan FIFO.
module tb_kb_read_sequencer;

  logic       clk = 1'b0;
  logic       Reset = 1'b0;
  logic       kb_avail = 1'b0;
  logic [7:0] kb_ascii = 8'h00;
  logic       kb_rd;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [2:0] fifo_level;
  logic [7:0] drop_count;
  logic       busy;

  kb_read_sequencer #(.DEPTH_LOG2(2), .HOLDOFF(2)) dut (
    .clk(clk), .Reset(Reset), .kb_avail(kb_avail), .kb_ascii(kb_ascii),
    .kb_rd(kb_rd), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .fifo_level(fifo_level), .drop_count(drop_count),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int pulses = 0;
  logic [7:0] scan_q[$];
  logic [7:0] rx[$];

  typedef struct {
    logic [7:0] ascii;
    int         exp_level;
    int         exp_drop;
    logic [7:0] exp_head;
  } vec_t;
  vec_t tbl[6];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expire(input string name);
    total++;
    bad++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  task automatic refresh_kb();
    kb_avail = (scan_q.size() != 0);
    kb_ascii = (scan_q.size() != 0) ? scan_q[0] : 8'h00;
  endtask

  task automatic push_key(input logic [7:0] a);
    scan_q.push_back(a);
    refresh_kb();
  endtask

  // One clock: keyboard pops on the edge that sees kb_rd, consumer takes
  // out_data on the edge that sees valid && ready.
  task automatic step();
    logic       rd_seen, take;
    logic [7:0] d;
    rd_seen = kb_rd;
    take    = out_valid && out_ready;
    d       = out_data;
    @(posedge clk);
    #1;
    if (rd_seen) begin
      pulses++;
      if (scan_q.size() != 0) void'(scan_q.pop_front());
    end
    if (take) rx.push_back(d);
    refresh_kb();
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    step();
    step();
    Reset = 1'b0;
    pulses = 0;
    rx.delete();
  endtask

  task automatic run_quiet(input string name, input int budget);
    int n;
    n = 0;
    while ((busy || (kb_avail && fifo_level != 3'd4)) && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) expire(name);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{8'h41, 1, 0, 8'h41};
    tbl[1] = '{8'h00, 1, 1, 8'h41};
    tbl[2] = '{8'h5A, 2, 1, 8'h41};
    tbl[3] = '{8'h00, 2, 2, 8'h41};
    tbl[4] = '{8'h7E, 3, 2, 8'h41};
    tbl[5] = '{8'h20, 4, 2, 8'h41};

    // Reset state
    do_reset();
    check("rst_kb_rd", kb_rd, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_level", fifo_level, 0);
    check("rst_drop", drop_count, 0);
    check("rst_busy", busy, 0);
    check("rst_out_data", out_data, 8'h00);

    // Single key timing: strobe visible during the cycle ending at edge 3
    push_key(8'h41);
    step();
    check("t2_e1_kb_rd", kb_rd, 0);
    check("t2_e1_busy", busy, 1);
    step();
    check("t2_e2_kb_rd", kb_rd, 1);
    check("t2_e2_valid", out_valid, 0);
    step();
    check("t2_e3_kb_rd", kb_rd, 0);
    check("t2_e3_valid", out_valid, 1);
    check("t2_e3_data", out_data, 8'h41);
    check("t2_e3_level", fifo_level, 1);
    run_quiet("t2_quiet", 20);
    check("t2_pulses", pulses, 1);
    check("t2_scan_left", scan_q.size(), 0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("t2_drain_level", fifo_level, 0);
    check("t2_drain_valid", out_valid, 0);
    check("t2_hold_data", out_data, 8'h41);
    check("t2_rx_count", rx.size(), 1);
    if (rx.size() == 1) check("t2_rx_data", rx[0], 8'h41);

    // Dropped codes and saturation
    do_reset();
    push_key(8'h00);
    run_quiet("t3_quiet", 20);
    check("t3_pulses", pulses, 1);
    check("t3_level", fifo_level, 0);
    check("t3_drop1", drop_count, 1);
    for (int i = 0; i < 299; i++) scan_q.push_back(8'h00);
    refresh_kb();
    run_quiet("t3_sat_quiet", 2000);
    check("t3_drop_sat", drop_count, 255);
    check("t3_pulses_all", pulses, 300);
    check("t3_level_sat", fifo_level, 0);

    // Table-driven single keys with the consumer stalled
    do_reset();
    for (int i = 0; i < 6; i++) begin
      push_key(tbl[i].ascii);
      run_quiet($sformatf("tbl%0d_quiet", i), 20);
      check($sformatf("tbl%0d_level", i), fifo_level, tbl[i].exp_level);
      check($sformatf("tbl%0d_drop", i), drop_count, tbl[i].exp_drop);
      check($sformatf("tbl%0d_head", i), out_data, tbl[i].exp_head);
      check($sformatf("tbl%0d_pulses", i), pulses, i + 1);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) step();
    out_ready = 1'b0;
    check("tbl_rx_count", rx.size(), 4);
    if (rx.size() == 4) begin
      check("tbl_rx0", rx[0], 8'h41);
      check("tbl_rx1", rx[1], 8'h5A);
      check("tbl_rx2", rx[2], 8'h7E);
      check("tbl_rx3", rx[3], 8'h20);
    end
    check("tbl_empty_data", out_data, 8'h20);

    // Backpressure: full local FIFO stalls with keys left in scan FIFO
    do_reset();
    for (int i = 0; i < 6; i++) scan_q.push_back(8'h31 + 8'(i));
    refresh_kb();
    run_quiet("t4_fill", 60);
    check("t4_level_full", fifo_level, 4);
    check("t4_scan_left", scan_q.size(), 2);
    check("t4_busy", busy, 0);
    for (int i = 0; i < 10; i++) step();
    check("t4_stall_pulses", pulses, 4);
    check("t4_stall_busy", busy, 0);
    check("t4_head", out_data, 8'h31);
    out_ready = 1'b1;
    begin
      int n;
      n = 0;
      while ((rx.size() < 6 || busy || fifo_level != 0) && n < 100) begin
        step();
        n++;
      end
      if (n >= 100) expire("t4_drain");
    end
    out_ready = 1'b0;
    check("t4_rx_count", rx.size(), 6);
    for (int i = 0; i < 6; i++)
      if (i < rx.size()) check($sformatf("t4_rx%0d", i), rx[i], 8'h31 + i);
    check("t4_pulses", pulses, 6);

    // Write and read on the same edge
    do_reset();
    push_key(8'h61);
    run_quiet("t5_first", 20);
    check("t5_level1", fifo_level, 1);
    push_key(8'h62);
    begin
      int n;
      n = 0;
      while (!kb_rd && n < 10) begin
        step();
        n++;
      end
      if (n >= 10) expire("t5_wait_pop");
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("t5_level_same", fifo_level, 1);
    check("t5_valid", out_valid, 1);
    check("t5_next_data", out_data, 8'h62);
    check("t5_rx_count", rx.size(), 1);
    if (rx.size() == 1) check("t5_rx0", rx[0], 8'h61);

    // Reset during LATCH: no strobe, key re-read once afterwards
    do_reset();
    push_key(8'h55);
    step();
    check("t6_in_latch", busy, 1);
    check("t6_no_rd_yet", kb_rd, 0);
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    check("t6_rst_kb_rd", kb_rd, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_key_kept", scan_q.size(), 1);
    check("t6_no_pulse", pulses, 0);
    run_quiet("t6_quiet", 20);
    check("t6_pulses", pulses, 1);
    check("t6_level", fifo_level, 1);
    check("t6_data", out_data, 8'h55);
    check("t6_scan_empty", scan_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
